// File: rtl/sort_v2_pkg.sv
// rtl/sort_v2_pkg.sv - shared types and compare helper for the Avalon-ST packet sorter
package sort_v2_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        SEND = 2'd2
    } state_t;

    // Words are widened to XW bits by the caller (sign- or zero-extended) so one helper serves every DWIDTH up to 64.
    localparam int XW = 65;

    function automatic int cnt_width(input int max_len);
        return $clog2(max_len + 1);
    endfunction

    // True when a must be emitted strictly before b; equal words never reorder, which keeps arrival order on ties.
    function automatic logic goes_before(input logic [XW-1:0] a,
                                         input logic [XW-1:0] b,
                                         input logic signed_mode,
                                         input logic desc);
        logic lt;
        logic gt;
        lt = signed_mode ? ($signed(a) < $signed(b)) : (a < b);
        gt = signed_mode ? ($signed(a) > $signed(b)) : (a > b);
        return desc ? gt : lt;
    endfunction

endpackage

// File: rtl/sort_insert_array.sv
// rtl/sort_insert_array.sv - word buffer kept sorted by a parallel compare/shift insertion each cycle
module sort_insert_array
    import sort_v2_pkg::*;
#(
    parameter int DWIDTH = 8,
    parameter int DEPTH  = 16,
    parameter int SIGNED = 0,
    parameter int CNT_W  = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_clr,
    input  logic              i_ins,
    input  logic              i_desc,
    input  logic [DWIDTH-1:0] i_data,
    input  logic [CNT_W-1:0]  i_count,
    input  logic [CNT_W-1:0]  i_rd_idx,
    output logic [DWIDTH-1:0] o_rd_data
);

    logic [DWIDTH-1:0] r_mem [DEPTH];
    logic [DWIDTH-1:0] w_below [DEPTH];
    logic [DEPTH-1:0]  w_after;
    logic [DEPTH-1:0]  w_prev;
    logic [DEPTH-1:0]  w_land;
    logic [CNT_W-1:0]  w_cnt;

    function automatic logic [XW-1:0] ext(input logic [DWIDTH-1:0] d);
        if (SIGNED != 0)
            return {{(XW-DWIDTH){d[DWIDTH-1]}}, d};
        else
            return {{(XW-DWIDTH){1'b0}}, d};
    endfunction

    // A clear restarts the packet, so the incoming word is compared against an empty buffer.
    assign w_cnt  = i_clr ? '0 : i_count;
    assign w_prev = {w_after[DEPTH-2:0], 1'b0};

    always_comb begin
        w_after    = '0;
        w_land     = '0;
        w_below[0] = '0;
        for (int k = 1; k < DEPTH; k++)
            w_below[k] = r_mem[k-1];
        for (int k = 0; k < DEPTH; k++)
            w_after[k] = (CNT_W'(k) < w_cnt) &&
                         goes_before(ext(i_data), ext(r_mem[k]), SIGNED != 0, i_desc);
        for (int k = 0; k < DEPTH; k++)
            w_land[k] = !w_prev[k] && (w_after[k] || (CNT_W'(k) == w_cnt));
    end

    always_comb begin
        o_rd_data = '0;
        for (int k = 0; k < DEPTH; k++)
            if (i_rd_idx == CNT_W'(k))
                o_rd_data = r_mem[k];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < DEPTH; k++)
                r_mem[k] <= '0;
        end else begin
            for (int k = 0; k < DEPTH; k++) begin
                if (i_ins && w_prev[k])
                    r_mem[k] <= w_below[k];
                else if (i_ins && w_land[k])
                    r_mem[k] <= i_data;
                else if (i_clr)
                    r_mem[k] <= '0;
            end
        end
    end

endmodule

// File: rtl/avst_sort_v2.sv
// rtl/avst_sort_v2.sv - Avalon-ST packet sorter: ingest with insertion sort, then replay in order
module avst_sort_v2
    import sort_v2_pkg::*;
#(
    parameter int DWIDTH      = 8,
    parameter int MAX_PKT_LEN = 16,
    parameter int SIGNED      = 0
) (
    input  logic              clk_i,
    input  logic              arst_i,
    input  logic              desc_i,
    input  logic [DWIDTH-1:0] snk_data_i,
    input  logic              snk_startofpacket_i,
    input  logic              snk_endofpacket_i,
    input  logic              snk_valid_i,
    output logic              snk_ready_o,
    output logic [DWIDTH-1:0] src_data_o,
    output logic              src_startofpacket_o,
    output logic              src_endofpacket_o,
    output logic              src_valid_o,
    input  logic              src_ready_i,
    output logic              pkt_err_o
);

    localparam int CNT_W = cnt_width(MAX_PKT_LEN);
    localparam logic [CNT_W-1:0] FULL = CNT_W'(MAX_PKT_LEN);

    state_t            r_state;
    logic [CNT_W-1:0]  r_count;
    logic [CNT_W-1:0]  r_rd_idx;
    logic              r_desc;
    logic              r_trunc;
    logic              r_snk_ready;
    logic              r_src_valid;
    logic              r_src_sop;
    logic              r_src_eop;
    logic              r_pkt_err;

    logic              w_acc;
    logic              w_sop_acc;
    logic              w_take;
    logic              w_room;
    logic              w_ins;
    logic              w_ins_desc;
    logic              w_xfer;
    logic [CNT_W-1:0]  w_next_cnt;
    logic [DWIDTH-1:0] w_rd_data;

    assign w_acc      = snk_valid_i && r_snk_ready;
    assign w_sop_acc  = w_acc && snk_startofpacket_i;
    assign w_take     = w_sop_acc || (w_acc && r_state == FILL);
    assign w_room     = (r_count != FULL);
    assign w_ins      = w_sop_acc || (w_acc && r_state == FILL && w_room);
    assign w_ins_desc = w_sop_acc ? desc_i : r_desc;
    assign w_xfer     = r_src_valid && src_ready_i;
    assign w_next_cnt = w_sop_acc ? CNT_W'(1) : (w_room ? r_count + CNT_W'(1) : r_count);

    sort_insert_array #(
        .DWIDTH (DWIDTH),
        .DEPTH  (MAX_PKT_LEN),
        .SIGNED (SIGNED),
        .CNT_W  (CNT_W)
    ) u_array (
        .clk       (clk_i),
        .rst       (arst_i),
        .i_clr     (w_sop_acc),
        .i_ins     (w_ins),
        .i_desc    (w_ins_desc),
        .i_data    (snk_data_i),
        .i_count   (r_count),
        .i_rd_idx  (r_rd_idx),
        .o_rd_data (w_rd_data)
    );

    assign snk_ready_o         = r_snk_ready;
    assign src_valid_o         = r_src_valid;
    assign src_startofpacket_o = r_src_sop;
    assign src_endofpacket_o   = r_src_eop;
    assign pkt_err_o           = r_pkt_err;
    // The buffer is frozen during SEND, so the read mux output is as stable as a register there.
    assign src_data_o          = r_src_valid ? w_rd_data : '0;

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            r_state     <= IDLE;
            r_count     <= '0;
            r_rd_idx    <= '0;
            r_desc      <= 1'b0;
            r_trunc     <= 1'b0;
            r_snk_ready <= 1'b1;
            r_src_valid <= 1'b0;
            r_src_sop   <= 1'b0;
            r_src_eop   <= 1'b0;
            r_pkt_err   <= 1'b0;
        end else begin
            r_pkt_err <= 1'b0;
            case (r_state)
                IDLE, FILL: begin
                    if (w_take) begin
                        r_count <= w_next_cnt;
                        if (snk_startofpacket_i) begin
                            r_desc    <= desc_i;
                            r_trunc   <= 1'b0;
                            r_pkt_err <= (r_state == FILL);
                        end else if (!w_room) begin
                            r_trunc <= 1'b1;
                        end
                        if (snk_endofpacket_i) begin
                            if (!snk_startofpacket_i)
                                r_pkt_err <= r_trunc || !w_room;
                            r_state     <= SEND;
                            r_snk_ready <= 1'b0;
                            r_src_valid <= 1'b1;
                            r_src_sop   <= 1'b1;
                            r_src_eop   <= (w_next_cnt == CNT_W'(1));
                            r_rd_idx    <= '0;
                            r_trunc     <= 1'b0;
                        end else begin
                            r_state <= FILL;
                        end
                    end
                end
                SEND: begin
                    if (w_xfer) begin
                        if (r_src_eop) begin
                            r_state     <= IDLE;
                            r_snk_ready <= 1'b1;
                            r_src_valid <= 1'b0;
                            r_src_sop   <= 1'b0;
                            r_src_eop   <= 1'b0;
                            r_count     <= '0;
                            r_rd_idx    <= '0;
                        end else begin
                            r_rd_idx  <= r_rd_idx + CNT_W'(1);
                            r_src_sop <= 1'b0;
                            r_src_eop <= (r_rd_idx + CNT_W'(2) == r_count);
                        end
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_snk_ready <= 1'b1;
                    r_src_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_avst_sort_v2.sv
// tb/tb_avst_sort_v2.sv - directed and randomised self-checking bench for avst_sort_v2
module tb_avst_sort_v2;

    logic       clk;
    logic       arst;
    logic       desc;
    logic [7:0] snk_data;
    logic       snk_sop;
    logic       snk_eop;
    logic       snk_valid;
    logic       src_ready;

    logic       u_snk_ready, u_sop, u_eop, u_valid, u_err;
    logic [7:0] u_data;
    logic       s_snk_ready, s_sop, s_eop, s_valid, s_err;
    logic [7:0] s_data;

    logic       sel_s;
    int         checks;
    int         errors;
    int         err_pulses;

    logic [7:0] exp_q[$];
    logic [7:0] pkt_q[$];

    avst_sort_v2 #(.DWIDTH(8), .MAX_PKT_LEN(16), .SIGNED(0)) u_dut (
        .clk_i(clk), .arst_i(arst), .desc_i(desc),
        .snk_data_i(snk_data), .snk_startofpacket_i(snk_sop), .snk_endofpacket_i(snk_eop),
        .snk_valid_i(snk_valid), .snk_ready_o(u_snk_ready),
        .src_data_o(u_data), .src_startofpacket_o(u_sop), .src_endofpacket_o(u_eop),
        .src_valid_o(u_valid), .src_ready_i(src_ready), .pkt_err_o(u_err)
    );

    avst_sort_v2 #(.DWIDTH(8), .MAX_PKT_LEN(16), .SIGNED(1)) s_dut (
        .clk_i(clk), .arst_i(arst), .desc_i(desc),
        .snk_data_i(snk_data), .snk_startofpacket_i(snk_sop), .snk_endofpacket_i(snk_eop),
        .snk_valid_i(snk_valid), .snk_ready_o(s_snk_ready),
        .src_data_o(s_data), .src_startofpacket_o(s_sop), .src_endofpacket_o(s_eop),
        .src_valid_o(s_valid), .src_ready_i(src_ready), .pkt_err_o(s_err)
    );

    wire       o_snk_ready = sel_s ? s_snk_ready : u_snk_ready;
    wire       o_valid     = sel_s ? s_valid : u_valid;
    wire       o_sop       = sel_s ? s_sop : u_sop;
    wire       o_eop       = sel_s ? s_eop : u_eop;
    wire [7:0] o_data      = sel_s ? s_data : u_data;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) if (u_err) err_pulses++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_beat(input logic [7:0] d, input logic sop, input logic eop,
                             input logic dsc, input int gap);
        int b;
        b = 0;
        repeat (gap) step();
        snk_valid = 1'b1;
        snk_data  = d;
        snk_sop   = sop;
        snk_eop   = eop;
        desc      = dsc;
        while (!o_snk_ready && b < 200) begin
            step();
            b++;
        end
        if (b >= 200) chk("snk_ready_timeout", b, 0);
        step();
        snk_valid = 1'b0;
        snk_sop   = 1'b0;
        snk_eop   = 1'b0;
    endtask

    task automatic send_pkt(input logic dsc, input int gapmax);
        for (int i = 0; i < pkt_q.size(); i++)
            send_beat(pkt_q[i], i == 0, i == pkt_q.size() - 1, dsc,
                      gapmax > 0 ? int'($urandom_range(0, gapmax)) : 0);
    endtask

    function automatic int key(input logic [7:0] v, input bit sgn);
        return sgn ? int'($signed(v)) : int'(v);
    endfunction

    task automatic ref_sort(input bit dsc, input bit sgn);
        logic [7:0] t;
        exp_q = pkt_q;
        for (int i = 0; i < exp_q.size(); i++)
            for (int j = 0; j + 1 < exp_q.size() - i; j++)
                if (dsc ? key(exp_q[j], sgn) < key(exp_q[j+1], sgn)
                        : key(exp_q[j], sgn) > key(exp_q[j+1], sgn)) begin
                    t = exp_q[j]; exp_q[j] = exp_q[j+1]; exp_q[j+1] = t;
                end
    endtask

    task automatic collect(input bit rnd);
        int         i;
        int         budget;
        int         n;
        logic       pv;
        logic [7:0] pd;
        logic       ps;
        logic       pe;
        i = 0; budget = 0; n = exp_q.size();
        pv = 1'b0; pd = '0; ps = 1'b0; pe = 1'b0;
        while (i < n && budget < 2000) begin
            src_ready = rnd ? ($urandom_range(0, 99) >= 30) : 1'b1;
            if (pv) begin
                chk("stall_valid", o_valid, 1);
                chk("stall_data", o_data, pd);
                chk("stall_sop", o_sop, ps);
                chk("stall_eop", o_eop, pe);
            end
            if (o_valid) begin
                if (src_ready) begin
                    chk("out_data", o_data, exp_q[i]);
                    chk("out_sop", o_sop, i == 0);
                    chk("out_eop", o_eop, i == n - 1);
                    i++;
                end
                pv = !src_ready; pd = o_data; ps = o_sop; pe = o_eop;
            end else begin
                pv = 1'b0;
            end
            step();
            budget++;
        end
        chk("collect_beats", i, n);
        chk("post_valid", o_valid, 0);
        chk("post_snk_ready", o_snk_ready, 1);
    endtask

    initial begin
        int e0;
        checks = 0; errors = 0; err_pulses = 0; sel_s = 1'b0;
        arst = 1'b1; desc = 1'b0; snk_data = '0; snk_sop = 1'b0; snk_eop = 1'b0;
        snk_valid = 1'b0; src_ready = 1'b1;
        repeat (3) step();
        chk("rst_snk_ready", u_snk_ready, 1);
        chk("rst_valid", u_valid, 0);
        chk("rst_sop_eop", {u_sop, u_eop}, 0);
        chk("rst_data", u_data, 0);
        chk("rst_err", u_err, 0);
        arst = 1'b0;
        step();

        // Unsigned ascending with a duplicate and latency check
        pkt_q = '{8'd200, 8'd3, 8'd77, 8'd3, 8'd0};
        exp_q = '{8'd0, 8'd3, 8'd3, 8'd77, 8'd200};
        send_pkt(1'b0, 0);
        chk("t1_latency_valid", u_valid, 1);
        chk("t1_snk_ready_low", u_snk_ready, 0);
        collect(1'b0);

        // Signed descending
        sel_s = 1'b1;
        pkt_q = '{8'h80, 8'h7F, 8'h00, 8'hFF};
        exp_q = '{8'h7F, 8'h00, 8'hFF, 8'h80};
        send_pkt(1'b1, 0);
        collect(1'b0);
        sel_s = 1'b0;

        // Single-word packet
        send_beat(8'd42, 1'b1, 1'b1, 1'b0, 0);
        chk("t3_valid", u_valid, 1);
        chk("t3_data", u_data, 42);
        chk("t3_sop", u_sop, 1);
        chk("t3_eop", u_eop, 1);
        chk("t3_snk_ready", u_snk_ready, 0);
        step();
        chk("t3_after_valid", u_valid, 0);
        chk("t3_after_ready", u_snk_ready, 1);

        // Oversize packet: 19 words then an EOP beat, first 16 kept
        e0 = err_pulses;
        pkt_q = {};
        for (int i = 0; i < 20; i++) pkt_q.push_back(8'((i * 37 + 11) & 255));
        send_pkt(1'b0, 0);
        chk("t4_err_pulse", u_err, 1);
        pkt_q = pkt_q[0:15];
        ref_sort(1'b0, 1'b0);
        collect(1'b0);
        chk("t4_err_count", err_pulses - e0, 1);

        // Abort on stray SOP mid-packet
        e0 = err_pulses;
        send_beat(8'd9, 1'b1, 1'b0, 1'b0, 0);
        send_beat(8'd8, 1'b0, 1'b0, 1'b0, 0);
        send_beat(8'd7, 1'b0, 1'b0, 1'b0, 0);
        send_beat(8'd5, 1'b1, 1'b0, 1'b0, 0);
        chk("t5_abort_pulse", u_err, 1);
        send_beat(8'd1, 1'b0, 1'b1, 1'b0, 0);
        exp_q = '{8'd1, 8'd5};
        collect(1'b0);
        chk("t5_err_count", err_pulses - e0, 1);

        // Non-SOP beat in IDLE is dropped
        e0 = err_pulses;
        send_beat(8'd99, 1'b0, 1'b1, 1'b0, 0);
        repeat (3) begin
            chk("t5_idle_no_valid", u_valid, 0);
            step();
        end
        chk("t5_idle_ready", u_snk_ready, 1);
        chk("t5_idle_no_err", err_pulses - e0, 0);
        pkt_q = '{8'd4, 8'd2};
        exp_q = '{8'd2, 8'd4};
        send_pkt(1'b0, 0);
        collect(1'b0);

        // Random packets with gaps and output backpressure
        for (int p = 0; p < 5; p++) begin
            logic dsc;
            int   len;
            dsc = 1'($urandom_range(0, 1));
            len = $urandom_range(1, 16);
            pkt_q = {};
            for (int i = 0; i < len; i++) pkt_q.push_back(8'($urandom_range(0, 255)));
            ref_sort(dsc, 1'b0);
            send_pkt(dsc, 2);
            collect(1'b1);
        end

        // Reset during SEND discards the packet
        src_ready = 1'b0;
        pkt_q = '{8'd3, 8'd1, 8'd2};
        send_pkt(1'b0, 0);
        chk("t6_valid_before_rst", u_valid, 1);
        step();
        arst = 1'b1;
        #1;
        chk("t6_rst_valid", u_valid, 0);
        chk("t6_rst_snk_ready", u_snk_ready, 1);
        chk("t6_rst_data", u_data, 0);
        @(negedge clk);
        arst = 1'b0;
        src_ready = 1'b1;
        repeat (3) begin
            step();
            chk("t6_no_partial", u_valid, 0);
        end
        pkt_q = '{8'd6, 8'd5};
        exp_q = '{8'd5, 8'd6};
        send_pkt(1'b0, 0);
        collect(1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
